usb_xact_sched: RTL
===================

USB_XACT_SCHED -- requirements
Module: usb_xact_sched

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req  input  2  per-requester transaction request, level; held until done/err for that requester.
REQ-004 req_dir  input  2  per-requester direction: 1 = IN (read), 0 = OUT (write); sampled at grant.
REQ-005 grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.
REQ-006 tx_start  output  1  one-cycle pulse requesting the packet transmitter to send tx_pid.
REQ-007 tx_pid  output  4  PID to transmit: OUT=0001, IN=1001, DATA0=0011, ACK=0010; 0000 when not transmitting.
REQ-008 tx_eop_en  input  1  pulse: transmitter finished current packet.
REQ-009 rx_pid_en, rx_pid  input  1, 4  pulse plus PID of a received handshake/token.
REQ-010 rx_eop_en  input  1  pulse: a data packet was received completely and CRC-good.
REQ-011 time_threshold  input  16  response timeout in clk cycles.
REQ-012 max_retry  input  2  retries allowed after the first attempt (0-3).
REQ-013 d_oe  output  1  bus direction: 1 = TX, 0 = RX.
REQ-014 busy, done, err  output  1 each  transaction active; one-cycle success pulse; one-cycle failure pulse.

Function
REQ-015 FSM states: IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, SEND_ACK, DONE, ERR.
REQ-016 IDLE: if any req bit is set, round-robin arbitration selects the owner; priority goes to the requester not granted last; after reset, requester 0 is preferred.
REQ-017 Grant registers in the same cycle as the IDLE->TOKEN transition; req_dir of the owner is latched; grant is held until the DONE/ERR exit.
REQ-018 Deassertion of the owner's req mid-transaction is ignored; the transaction completes or fails normally.
REQ-019 Entry to TOKEN, DATA_TX or SEND_ACK: tx_start pulses exactly one cycle on the first cycle in the state; tx_pid holds the state's PID for the whole state.
REQ-020 TOKEN (PID OUT/IN per latched dir) exits on tx_eop_en to DATA_TX if dir=OUT, or to WAIT_DATA if dir=IN.
REQ-021 DATA_TX (DATA0) exits on tx_eop_en to WAIT_HS.
REQ-022 WAIT_HS: rx_pid_en with rx_pid=0010 -> DONE; rx_pid_en with any other PID -> retry; timeout -> retry.
REQ-023 WAIT_DATA: rx_eop_en -> SEND_ACK; timeout -> retry; rx_pid_en is ignored.
REQ-024 SEND_ACK (PID ACK) exits on tx_eop_en to DONE.
REQ-025 Timer: 16-bit; cleared to 0 on entry to WAIT_HS or WAIT_DATA; increments by 1 per cycle while in the wait state; timeout fires when timer == time_threshold (threshold 0 means timeout on the first wait cycle).
REQ-026 When a valid response and a timeout occur in the same cycle, the response wins.
REQ-027 Retry: if retry_cnt == max_retry -> ERR; otherwise retry_cnt increments and the FSM returns to TOKEN (new tx_start). retry_cnt clears at each grant.
REQ-028 DONE / ERR last exactly one cycle: done or err pulses, grant clears at exit, and the next state is IDLE. No new grant occurs in the DONE/ERR cycle.
REQ-029 d_oe = 1 in IDLE, TOKEN, DATA_TX and SEND_ACK; d_oe = 0 in WAIT_HS and WAIT_DATA; d_oe = 1 in DONE and ERR.
REQ-030 busy = 1 in every state except IDLE.
REQ-031 tx_eop_en, rx_eop_en and rx_pid_en arriving in states that do not consume them have no effect.

Reset
REQ-032 rst_n low (any time, including mid-transaction) drives the following immediately: state=IDLE, grant=00, tx_start=0, tx_pid=0000, d_oe=1, busy=0, done=0, err=0, timer=0, retry_cnt=0, and the round-robin pointer prefers requester 0.
REQ-033 After rst_n deasserts, no tx_start occurs before a req is sampled in IDLE.

Verification
REQ-034 OUT success: req=01, req_dir=00; tx_eop_en after TOKEN and after DATA0; rx_pid=0010 -> tx_pid sequence 0001, 0011; done pulses once; grant 01 -> 00; d_oe goes 0 only in WAIT_HS.
REQ-035 IN success: req=10, req_dir=10; token sent; rx_eop_en arrives -> tx_pid 1001, then 0010; done pulses once.
REQ-036 Timeout/retry: time_threshold=5, max_retry=1, no response -> two TOKEN tx_start pulses, each wait lasting exactly 6 cycles (timer 0..5); err pulses once; done never asserts.
REQ-037 Arbitration: req=11 held continuously -> grants alternate 01, 10, 01; a NAK PID (1010) in WAIT_HS triggers a retry.
REQ-038 Reset mid-operation: rst_n low during WAIT_HS -> all outputs at reset values within the same cycle; no done/err pulse.
REQ-039 Tie: rx_pid_en with ACK in the same cycle as timer == time_threshold -> done pulses and err stays 0.

Source files
------------

// File: rtl/usb_xact_sched_if.sv
// usb_xact_sched_if
//   Bundles the request/grant handshake, transmitter/receiver strobes,
//   configuration and status signals of the USB transaction scheduler.
//   master : requesters + PHY side (drives requests, strobes, config)
//   slave  : the scheduler (drives grant, tx_start/tx_pid, d_oe, status)
interface usb_xact_sched_if;
  logic [1:0]  req;             // per-requester request, level
  logic [1:0]  req_dir;         // per-requester direction, 1 = IN
  logic [1:0]  grant;           // one-hot owner, 00 when idle
  logic        tx_start;        // one-cycle send request
  logic [3:0]  tx_pid;          // PID to transmit
  logic        tx_eop_en;       // transmitter finished packet
  logic        rx_pid_en;       // received handshake/token strobe
  logic [3:0]  rx_pid;          // received PID
  logic        rx_eop_en;       // data packet received, CRC good
  logic [15:0] time_threshold;  // response timeout in cycles
  logic [1:0]  max_retry;       // retries after the first attempt
  logic        d_oe;            // 1 = TX, 0 = RX
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req, req_dir, tx_eop_en, rx_pid_en, rx_pid, rx_eop_en,
           time_threshold, max_retry,
    input  grant, tx_start, tx_pid, d_oe, busy, done, err
  );

  modport slave (
    input  req, req_dir, tx_eop_en, rx_pid_en, rx_pid, rx_eop_en,
           time_threshold, max_retry,
    output grant, tx_start, tx_pid, d_oe, busy, done, err
  );
endinterface

// File: rtl/usb_xact_sched.sv
// usb_xact_sched
//   Two-requester USB host transaction scheduler. Arbitrates round-robin,
//   sequences TOKEN -> DATA0 -> handshake (OUT) or TOKEN -> data -> ACK (IN),
//   times out waiting for responses and retries up to max_retry times.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_if : usb_xact_sched_if.slave (requests, strobes, config, status)
module usb_xact_sched (
  input  logic                    clk,
  input  logic                    rst_n,
  usb_xact_sched_if.slave         bus_if
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TOKEN     = 3'd1;
  localparam logic [2:0] ST_DATA_TX   = 3'd2;
  localparam logic [2:0] ST_WAIT_HS   = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_SEND_ACK  = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERR       = 3'd7;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  logic [2:0]  state_q, state_d;
  logic [1:0]  grant_q;
  logic        dir_q;
  logic        prio_q;        // index of the preferred requester on a tie
  logic        tx_start_q;
  logic [15:0] timer_q;
  logic [1:0]  retry_cnt_q;

  logic        owner_idx;
  logic        in_wait;
  logic        timeout;
  logic [2:0]  retry_state;

  // With both requesting, the pointer decides; otherwise the lone requester.
  assign owner_idx   = (bus_if.req == 2'b11) ? prio_q : bus_if.req[1];
  assign in_wait     = (state_q == ST_WAIT_HS) || (state_q == ST_WAIT_DATA);
  assign timeout     = (timer_q == bus_if.time_threshold);
  assign retry_state = (retry_cnt_q == bus_if.max_retry) ? ST_ERR : ST_TOKEN;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (|bus_if.req) state_d = ST_TOKEN;
      ST_TOKEN:     if (bus_if.tx_eop_en) state_d = dir_q ? ST_WAIT_DATA : ST_DATA_TX;
      ST_DATA_TX:   if (bus_if.tx_eop_en) state_d = ST_WAIT_HS;
      // A response in the same cycle as the timeout takes precedence.
      ST_WAIT_HS: begin
        if (bus_if.rx_pid_en && (bus_if.rx_pid == PID_ACK)) state_d = ST_DONE;
        else if (bus_if.rx_pid_en || timeout)               state_d = retry_state;
      end
      ST_WAIT_DATA: begin
        if (bus_if.rx_eop_en) state_d = ST_SEND_ACK;
        else if (timeout)     state_d = retry_state;
      end
      ST_SEND_ACK:  if (bus_if.tx_eop_en) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      ST_ERR:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      dir_q       <= 1'b0;
      prio_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      timer_q     <= 16'd0;
      retry_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;

      // Pulse on the first cycle of every transmitting state, including
      // re-entry to TOKEN on retry.
      tx_start_q <= (state_d != state_q) &&
                    ((state_d == ST_TOKEN) || (state_d == ST_DATA_TX) ||
                     (state_d == ST_SEND_ACK));

      // Counts cycles spent in the current wait state; zero elsewhere so
      // every entry starts from 0.
      if (in_wait && (state_d == state_q)) timer_q <= timer_q + 16'd1;
      else                                 timer_q <= 16'd0;

      if ((state_q == ST_IDLE) && (state_d == ST_TOKEN)) begin
        grant_q     <= owner_idx ? 2'b10 : 2'b01;
        dir_q       <= bus_if.req_dir[owner_idx];
        prio_q      <= ~owner_idx;
        retry_cnt_q <= 2'd0;
      end else if ((state_q == ST_DONE) || (state_q == ST_ERR)) begin
        grant_q <= 2'b00;
      end

      if (in_wait && (state_d == ST_TOKEN)) retry_cnt_q <= retry_cnt_q + 2'd1;
    end
  end

  always_comb begin
    bus_if.tx_pid = 4'b0000;
    case (state_q)
      ST_TOKEN:    bus_if.tx_pid = dir_q ? PID_IN : PID_OUT;
      ST_DATA_TX:  bus_if.tx_pid = PID_DATA0;
      ST_SEND_ACK: bus_if.tx_pid = PID_ACK;
      default:     bus_if.tx_pid = 4'b0000;
    endcase
  end

  assign bus_if.grant    = grant_q;
  assign bus_if.tx_start = tx_start_q;
  assign bus_if.d_oe     = ~in_wait;
  assign bus_if.busy     = (state_q != ST_IDLE);
  assign bus_if.done     = (state_q == ST_DONE);
  assign bus_if.err      = (state_q == ST_ERR);

endmodule
